// File: rtl/dac_volt_steps_pkg.sv
// Shared types and constants for the button-driven DAC staircase writer.
// Frame layout is {config nibble, 12-bit DAC code}, shifted MSB first.
package dac_volts_pkg;

   localparam int FRAME_W = 16;
   localparam int DAC_W   = 12;
   localparam int CFG_W   = FRAME_W - DAC_W;

   // Channel A, unbuffered reference, 1x gain, output active.
   localparam logic [CFG_W-1:0] CFG_NIBBLE_DEF = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } spi_state_e;

   function automatic logic [FRAME_W-1:0] make_frame(
      input logic [CFG_W-1:0] cfg,
      input logic [DAC_W-1:0] code
   );
      return {cfg, code};
   endfunction

endpackage

// File: rtl/dac_volt_steps_if.sv
// Write-only SPI link to the DAC: the shifter drives it, observers listen.
// Handshake: cs low frames one word; mosi is valid around every sck rise.
interface dac_volt_steps_if;

   logic mosi;
   logic sck;
   logic cs;

   modport master (output mosi, output sck, output cs);
   modport slave  (input  mosi, input  sck, input  cs);

endinterface

// File: rtl/dac_volt_steps_spi_tx16.sv
// Generic 16-bit mode-0 SPI shifter: one start pulse sends one frame,
// done pulses for a single cycle as chip select is released.
module spi_tx16
   import dac_volts_pkg::*;
#(
   parameter int SCK_HALF = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   output logic               done,
   output spi_state_e         state,
   dac_volt_steps_if.master   spi
);

   localparam int DIV_W = (2 * SCK_HALF > 1) ? $clog2(2 * SCK_HALF) : 1;
   localparam int BIT_W = $clog2(FRAME_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCK_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_HALF);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

   spi_state_e         state_q, state_n;
   logic [DIV_W-1:0]   div_q, div_n;
   logic [BIT_W-1:0]   bit_q, bit_n;
   logic [FRAME_W-1:0] shreg_q, shreg_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_n;
         div_q   <= div_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
      end
   end

   // One SCK period is 2*SCK_HALF clocks; the shift happens on the wrap,
   // which is also the clock where sck falls.
   always_comb begin
      state_n = state_q;
      div_n   = div_q;
      bit_n   = bit_q;
      shreg_n = shreg_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_n = frame;
               div_n   = '0;
               bit_n   = '0;
               state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_n = '0;
               if (bit_q == BIT_LAST) begin
                  state_n = ST_DONE;
               end else begin
                  bit_n   = bit_q + 1'b1;
                  shreg_n = {shreg_q[FRAME_W-2:0], 1'b0};
               end
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign spi.cs   = (state_q != ST_SHIFT);
   assign spi.sck  = (state_q == ST_SHIFT) && (div_q >= DIV_HALF);
   assign spi.mosi = (state_q == ST_SHIFT) && shreg_q[FRAME_W-1];
   assign done     = (state_q == ST_DONE);
   assign state    = state_q;

endmodule

// File: rtl/dac_volt_steps.sv
// Push-button DAC stepper: each clean button press writes the current code
// to the DAC, then advances the code by STEP_CODE (12-bit wrap).
module dac_volt_steps
   import dac_volts_pkg::*;
#(
   parameter int               SCK_HALF   = 4,
   parameter logic [DAC_W-1:0] STEP_CODE  = 12'd256,
   parameter logic [CFG_W-1:0] CFG_NIBBLE = CFG_NIBBLE_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_i,
   output logic mosi_o,
   output logic sck_o,
   output logic cs_o,
   output logic eov_o
);

   logic             btn_meta;
   logic             btn_sync;
   logic             btn_prev;
   logic             start_q;
   logic [DAC_W-1:0] code_q;
   logic             done;
   logic             busy;
   spi_state_e       fsm_state;

   dac_volt_steps_if spi_bus ();

   // Two flops for metastability, a third for the rising-edge compare.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_prev <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         btn_meta <= button_i;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         start_q  <= btn_sync & ~btn_prev;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         code_q <= '0;
      end else if (done) begin
         code_q <= code_q + STEP_CODE;
      end
   end

   // Presses that land while a frame is in flight are dropped, never queued.
   assign busy = (fsm_state != ST_IDLE);

   spi_tx16 #(
      .SCK_HALF (SCK_HALF)
   ) u_tx (
      .clk   (clk_i),
      .rst   (rst_i),
      .start (start_q & ~busy),
      .frame (make_frame(CFG_NIBBLE, code_q)),
      .done  (done),
      .state (fsm_state),
      .spi   (spi_bus.master)
   );

   assign mosi_o = spi_bus.mosi;
   assign sck_o  = spi_bus.sck;
   assign cs_o   = spi_bus.cs;
   assign eov_o  = done;

endmodule

// File: tb/tb_dac_volt_steps.sv
// Bench for dac_volt_steps: random presses against a code/frame model,
// with an SPI monitor decoding every frame on sck rising edges.
module tb_dac_volt_steps;
   import dac_volts_pkg::*;

   localparam int SCK_HALF  = 4;
   localparam int FRAME_CYC = 16 * 2 * SCK_HALF;
   localparam int LAT_CS    = 3;
   localparam int LAT_EOV   = LAT_CS + FRAME_CYC;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic button;
   logic mosi, sck, cs, eov;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dac_volt_steps #(
      .SCK_HALF   (SCK_HALF),
      .STEP_CODE  (12'd256),
      .CFG_NIBBLE (4'b0011)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .button_i (button),
      .mosi_o   (mosi),
      .sck_o    (sck),
      .cs_o     (cs),
      .eov_o    (eov)
   );

   dac_volt_steps_if mon ();
   assign mon.mosi = mosi;
   assign mon.sck  = sck;
   assign mon.cs   = cs;

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_q[$];
   int exp_code = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Model: each accepted press writes {0x3, code}; code then steps mod 4096.
   task automatic push_expected();
      exp_q.push_back(16'h3000 | 16'(exp_code));
      exp_code = (exp_code + 256) % 4096;
   endtask

   // ---------------- monitor ----------------
   int frames_seen = 0;
   int eov_total = 0;
   int stray_eov = 0;
   int sck_idle_viol = 0;
   int mosi_viol = 0;
   int low_cnt = 0;
   int rise_cnt = 0;
   int last_rise = 0;
   int press_cyc = 0;
   bit lat_armed = 0;
   logic [15:0] shift_in = '0;
   logic cs_prev = 1'b1, sck_prev = 1'b0, mosi_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         low_cnt  = 0;
         rise_cnt = 0;
         shift_in = '0;
      end else begin
         if (eov) begin
            eov_total++;
            if (cs_prev) stray_eov++;
         end
         if (mon.cs && mon.sck) sck_idle_viol++;
         if (!mon.cs) begin
            if (cs_prev && lat_armed) chk("cs_fall_latency", cyc - press_cyc, LAT_CS);
            if (!cs_prev && mon.mosi !== mosi_prev && !(sck_prev && !mon.sck)) mosi_viol++;
            low_cnt++;
            if (mon.sck && !sck_prev) begin
               if (rise_cnt > 0) chk("sck_period", cyc - last_rise, 2 * SCK_HALF);
               last_rise = cyc;
               rise_cnt++;
               shift_in = {shift_in[14:0], mon.mosi};
            end
         end else if (!cs_prev) begin
            frames_seen++;
            chk("cs_low_cycles", low_cnt, FRAME_CYC);
            chk("sck_rises", rise_cnt, 16);
            chk("eov_at_cs_rise", eov, 1);
            if (exp_q.size() > 0) chk("frame_data", shift_in, exp_q.pop_front());
            else chk("frame_unexpected", shift_in, 32'h0001_0000);
            if (lat_armed) begin
               chk("eov_latency", cyc - press_cyc, LAT_EOV);
               lat_armed = 0;
            end
            low_cnt  = 0;
            rise_cnt = 0;
         end
      end
      cs_prev   = mon.cs;
      sck_prev  = mon.sck;
      mosi_prev = mon.mosi;
   end

   // ---------------- driver tasks ----------------
   task automatic press(input int len, input bit accepted);
      @(negedge clk);
      #1;
      button = 1'b1;
      if (accepted) begin
         push_expected();
         press_cyc = cyc + 1;
         lat_armed = 1;
      end
      repeat (len) @(posedge clk);
      #1;
      button = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_seen < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("frame_wait", frames_seen >= target, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int base;
      rst    = 1'b1;
      button = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_cs", cs, 1);
      chk("reset_sck", sck, 0);
      chk("reset_mosi", mosi, 0);
      chk("reset_eov", eov, 0);
      #1 rst = 1'b0;

      idle(200);
      chk("idle_frames", frames_seen, 0);
      chk("idle_sck", sck_idle_viol, 0);

      // Three single-cycle presses: 0x3000, 0x3100, 0x3200.
      for (int i = 0; i < 3; i++) begin
         press(1, 1);
         wait_frames(i + 1, 400);
         idle($urandom_range(5, 40));
      end
      chk("eov_one_per_frame", eov_total, 3);

      // Button held through the whole frame: one frame only.
      press(300, 1);
      wait_frames(4, 400);
      idle(200);
      chk("held_single_frame", frames_seen, 4);

      // Re-press during SHIFT is ignored.
      press(1, 1);
      idle($urandom_range(20, 90));
      press(2, 0);
      wait_frames(5, 400);
      idle(200);
      chk("repress_single_frame", frames_seen, 5);

      // Reset mid-frame: cs back high at once, no eov, code back to zero.
      press(1, 1);
      idle($urandom_range(20, 100));
      @(negedge clk);
      #1;
      rst = 1'b1;
      lat_armed = 0;
      exp_q.delete();
      exp_code = 0;
      @(negedge clk);
      chk("midrst_cs", cs, 1);
      chk("midrst_eov", eov, 0);
      chk("midrst_sck", sck, 0);
      #1 rst = 1'b0;
      idle(200);
      chk("midrst_no_frame", frames_seen, 5);
      chk("midrst_no_eov", eov_total, 5);

      // 17 presses from a fresh code: 16th is 0x3F00, 17th wraps to 0x3000.
      base = frames_seen;
      for (int i = 0; i < 17; i++) begin
         press($urandom_range(1, 20), 1);
         if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(10, 90));
            press(1, 0);
         end
         wait_frames(base + i + 1, 400);
         idle($urandom_range(0, 30));
      end

      idle(50);
      chk("queue_drained", exp_q.size(), 0);
      chk("eov_total", eov_total, frames_seen);
      chk("stray_eov", stray_eov, 0);
      chk("mosi_stable", mosi_viol, 0);
      chk("sck_idle_low", sck_idle_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
